// File: rtl/serv_ifetch_pkg.sv
// Shared constants and entry type for the instruction-fetch stage.
// An entry packs instruction bits [31:2] above its 32-bit PC.
package serv_ifetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [1:0]  WORD_ALIGN   = 2'b00;
  localparam int          ENTRY_W      = 62;
  typedef logic [ENTRY_W-1:0] entry_t;
endpackage

// File: rtl/serv_ifetch_fifo.sv
// Small register FIFO holding prefetched {instr[31:2], pc} entries.
// Flush wins over push and pop in the same cycle.
module serv_ifetch_fifo
  import serv_ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  entry_t                     i_din,
  output entry_t                     o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            wr_en;
  logic            rd_en;

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == CW'(DEPTH));
  assign wr_en   = i_push & (~o_full | i_pop);
  assign rd_en   = i_pop & ~o_empty;
  assign o_dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !i_flush)
      mem[wr_ptr] <= i_din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end
endmodule

// File: rtl/serv_ifetch.sv
// Instruction fetch: Wishbone ibus master with a prefetch buffer,
// one registered delivery pulse per core request, flush on redirect.
module serv_ifetch
  import serv_ifetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic [29:0] o_wb_rdt,
  output logic        o_wb_en,
  output logic [31:0] o_pc,
  output logic        o_empty
);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic          drop;
  logic          cyc_ack;
  logic          deliver;
  logic          push;
  logic          room;
  logic          issue;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  entry_t        head;
  logic          unused;

  assign o_ibus_cyc = (state == BUSY);
  assign cyc_ack    = o_ibus_cyc & i_ibus_ack;
  assign deliver    = i_req & ~o_wb_en & ~o_empty & ~i_redirect;
  assign push       = cyc_ack & ~drop & ~i_redirect;
  assign room       = ~fifo_full | deliver;
  assign issue      = ~o_ibus_cyc & ~i_redirect & room;
  assign unused     = ^{i_ibus_rdt[1:0], i_redirect_pc[1:0], fifo_count};

  serv_ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect),
    .i_push  (push),
    .i_pop   (deliver),
    .i_din   ({i_ibus_rdt[31:2], o_ibus_adr}),
    .o_dout  (head),
    .o_count (fifo_count),
    .o_empty (o_empty),
    .o_full  (fifo_full)
  );

  // After an ack the bus idles exactly one cycle before the next issue.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        BUSY:    if (i_ibus_ack) state <= GAP;
        default: state <= issue ? BUSY : IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_ibus_adr <= RESET_PC;
      fetch_pc   <= RESET_PC;
      drop       <= 1'b0;
    end else begin
      if (issue)
        o_ibus_adr <= fetch_pc;
      if (i_redirect)
        fetch_pc <= {i_redirect_pc[31:2], WORD_ALIGN};
      else if (push)
        fetch_pc <= fetch_pc + 32'd4;
      // An outstanding cycle from the old stream completes but is discarded.
      if (cyc_ack)
        drop <= 1'b0;
      else if (i_redirect && o_ibus_cyc)
        drop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_wb_en  <= 1'b0;
      o_wb_rdt <= '0;
      o_pc     <= RESET_PC;
    end else begin
      o_wb_en <= deliver;
      if (deliver)
        {o_wb_rdt, o_pc} <= head;
    end
  end
endmodule

// File: doc/serv_ifetch.md
Name: serv_ifetch

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Acts as a Wishbone-classic ibus master and prefetches sequential instruction words into a small buffer.
- Delivers one instruction to the decoder per core request as a registered one-cycle pulse (o_wb_en) carrying bits [31:2] and the instruction's PC.
- Flushes and restarts at a new address on redirect (taken branch, jump, trap, mret/dret).

Parameters:
- DEPTH, 2, instruction buffer entries; legal values 2 or 4.
- RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_req  input  1  core requests next instruction (level); core drops it in the cycle o_wb_en is high
- i_redirect  input  1  one-cycle pulse: flush buffer, restart fetch at i_redirect_pc
- i_redirect_pc  input  32  redirect target; bits [1:0] ignored
- o_ibus_adr  output  32  Wishbone fetch address, word aligned
- o_ibus_cyc  output  1  Wishbone cycle/strobe
- i_ibus_rdt  input  32  Wishbone read data
- i_ibus_ack  input  1  Wishbone acknowledge
- o_wb_rdt  output  30  delivered instruction bits [31:2]
- o_wb_en  output  1  one-cycle pulse: o_wb_rdt/o_pc valid, decoder latches
- o_pc  output  32  PC of delivered instruction
- o_empty  output  1  buffer holds no instruction

Behaviour:
- Reset (sync, i_rst=1, overrides everything):
  - o_ibus_cyc=0, o_wb_en=0, o_wb_rdt=0, o_pc=RESET_PC, o_empty=1, o_ibus_adr=RESET_PC.
  - Fetch pointer=RESET_PC, buffer count=0, drop flag=0.
  - An in-flight bus cycle is abandoned; an ack in the cycle after reset deasserts is ignored because cyc is low.
- Issue:
  - When cyc=0 and count+0 < DEPTH, the block raises o_ibus_cyc with o_ibus_adr=fetch pointer in the next cycle.
  - cyc and adr stay stable until i_ibus_ack.
- Ack (cyc=1, ack=1):
  - cyc drops for exactly one cycle; no back-to-back cycles.
  - If drop=0: push {i_ibus_rdt[31:2], adr} and fetch pointer += 4 (wraps mod 2^32).
  - If drop=1: discard the data and clear drop.
  - At most one outstanding bus cycle.
  - A new issue requires count < DEPTH evaluated after this cycle's push/pop.
- Delivery condition: i_req & ~o_wb_en & ~o_empty & ~i_redirect.
  - When true, the next cycle has o_wb_en=1, o_wb_rdt/o_pc = head entry, and the head is popped.
  - o_wb_rdt/o_pc hold their values until the next delivery.
  - Latency: request against a non-empty buffer -> o_wb_en 1 cycle later.
  - Request against an empty buffer -> delivery 1 cycle after the push.
  - Bus combinational ack in the same cycle as cyc rise: minimum 3 cycles from request to o_wb_en on a cold buffer.
- Push and pop in the same cycle are legal; count unchanged.
- Full (count=DEPTH): no issue. Empty: no delivery, o_empty=1.
- Redirect (highest priority after reset):
  - Next cycle: count=0, o_empty=1, fetch pointer={i_redirect_pc[31:2],2'b00}, no o_wb_en.
  - If cyc=1 and no ack this cycle: drop<=1; cyc stays high to complete the old cycle, and its data is discarded.
  - If ack arrives in the redirect cycle: data discarded, drop stays 0.
  - First fetch of the new stream issues after cyc has been low one cycle.
  - A redirect while drop=1 only updates the fetch pointer.
- The instruction's low two bits are not stored (always 2'b11 for RV32I).

Decomposition:
- Shared package: RESET_PC default and the Wishbone word-alignment constant; no typedefs beyond the entry width (62 bits = 30 instr + 32 pc).
- One sub-module, serv_ifetch_fifo:
  - DEPTH-entry register FIFO with push, pop, flush, count, empty, full.
  - Synchronous flush has priority over push.
- The top level holds the bus FSM (IDLE, BUSY, GAP), fetch pointer, drop flag and output registers.

Test Plan:
- Reset then i_req held, ack one cycle after cyc, mem[0]=32'h00500093 -> o_ibus_adr=0; o_wb_en pulse with o_wb_rdt=30'h00140024, o_pc=0; next fetch adr=4.
- i_req never asserted, DEPTH=2 -> exactly two bus cycles (adr 0, 4), then cyc stays 0; o_empty=0; request then yields pc 0 then pc 4 on successive requests.
- Redirect to 32'h00000102 while cyc=1 awaiting ack; ack 3 cycles later with 32'hDEADBEEF -> data never delivered; next cyc adr=32'h00000100; first o_pc=32'h100.
- Redirect in the same cycle as ack, and in the same cycle as a valid delivery condition -> no o_wb_en next cycle; acked data discarded; buffer empty.
- Fetch pointer at 32'hFFFFFFFC, ack -> next o_ibus_adr=32'h00000000.
- Assert i_rst mid bus cycle with count=1 -> next cycle cyc=0, o_empty=1, o_wb_en=0, o_ibus_adr=RESET_PC; later refetch starts at RESET_PC.
